alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer that sits on the initiator side of the 1-bit ALU slice interface.
- Accepts full-width operands and a 4-bit ALU_control, then drives the slice signals one bit per cycle, LSB first: src1/src2 bit, less, A_invert, B_invert, cin, operation.
- Chains the carry between cycles, resolves set-less-than after the MSB, and returns a full-width result with zero/cout/overflow flags.
- Used where area matters more than latency; the slice evaluation is instantiated internally.

Parameters:
WIDTH, 32, operand/result width in bits (≥2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
src1  input  WIDTH  operand A, sampled on accepted start
src2  input  WIDTH  operand B, sampled on accepted start
ALU_control  input  4  {A_invert, B_invert, operation[1:0]}, sampled on accepted start
busy  output  1  high from cycle after accept until done cycle inclusive
done  output  1  one-cycle pulse; result/flags valid from this cycle
result  output  WIDTH  final result, held until next done
zero  output  1  result == 0, updated with result
cout  output  1  carry out of MSB (ADD/SUB/SLT), else 0
overflow  output  1  signed overflow (ADD/SUB only), else 0

Behaviour:
- Reset: state=IDLE; busy, done, result, zero, cout, overflow all 0; internal shift/carry registers cleared.
- Supported ALU_control codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
  - Any other code runs the same sequence; the delivered result is 0 and all flags are 0.
- FSM states and transitions:
  - IDLE: start=1 latches operands/control, sets bit index i=0, sets carry=B_invert, goes to RUN.
  - RUN: one slice evaluation per cycle on bit i with cin=carry and less=0. The slice result bit shifts into the internal result register and carry is updated. At i=WIDTH-1, record carry-in and carry-out of the MSB and the MSB sum bit. Go to SLT_FIX if operation=11, else FIN.
  - SLT_FIX: set = sum_msb XOR (cin_msb XOR cout_msb). Write result bit0 = set; bits WIDTH-1..1 are already 0. Go to FIN.
  - FIN: copy the internal register to result, compute zero, drive cout/overflow, pulse done=1, return to IDLE. busy drops the cycle after FIN.
- Flag rules:
  - overflow = cin_msb XOR cout_msb for ADD/SUB, else 0.
  - cout = cout_msb for ADD/SUB/SLT, else 0.
- Latency, with the accept cycle as T0:
  - Non-SLT: done at T0+WIDTH+1.
  - SLT: done at T0+WIDTH+2.
- start while busy is ignored; no queuing. Inputs may change freely after accept.
- start in the FIN cycle is ignored. start is accepted in IDLE the next cycle, so back-to-back operations are separated by one idle cycle.
- rst during RUN/SLT_FIX/FIN aborts with no done pulse and clears result/flags. rst wins over simultaneous start.
- Bit index counter is $clog2(WIDTH) bits wide and must not wrap mid-operation.

Test Plan:
- Reset, then ADD src1=0x7FFFFFFF, src2=0x00000001 -> done at T0+33; result=0x80000000, overflow=1, cout=0, zero=0.
- SUB src1=5, src2=5 -> result=0x00000000, zero=1, cout=1, overflow=0, done at T0+33.
- SLT src1=0xFFFFFFFF (-1), src2=1 -> result=0x00000001, done at T0+34. SLT src1=0x7FFFFFFF, src2=0x80000000 (overflowing subtract) -> result=0x00000000.
- NOR src1=0, src2=0 -> result=0xFFFFFFFF, cout=0, overflow=0. AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000. OR of the same operands -> 0xFFF0FFF0.
- start pulsed again at T0+10 with different operands during an ADD -> ignored; the first result is delivered, and busy stays high until done.
- rst asserted at T0+15 of an ADD -> no done; next cycle busy=0 and result=0. A new start afterwards completes normally. Unsupported code 0011 -> result=0, done still pulses.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer driving a 1-bit ALU slice, LSB first.
// Chains carry across cycles, resolves SLT after the MSB, returns flags.

module alu_slice (
    input  logic       src1,
    input  logic       src2,
    input  logic       less,
    input  logic       A_invert,
    input  logic       B_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout,
    output logic       set
);

    logic a;
    logic b;

    // One-bit AND/OR/ADD/LESS evaluation with optional input inversion
    always_comb begin
        a      = src1 ^ A_invert;
        b      = src2 ^ B_invert;
        set    = a ^ b ^ cin;
        cout   = (a & b) | (a & cin) | (b & cin);
        result = 1'b0;
        unique case (operation)
            2'b00: result = a & b;
            2'b01: result = a | b;
            2'b10: result = set;
            2'b11: result = less;
        endcase
    end

endmodule

module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SLT_FIX,
        FIN
    } state_t;

    state_t state;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctrl_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             cin_msb_q;
    logic             cout_msb_q;
    logic             sum_msb_q;

    logic             last;
    logic             slt_set;
    logic             sl_res;
    logic             sl_cout;
    logic             sl_set;
    logic             cin_m;
    logic             cout_m;
    logic             is_arith;
    logic             is_slt;
    logic             supported;
    logic             to_fin;

    alu_slice u_slice (
        .src1      (a_q[idx_q]),
        .src2      (b_q[idx_q]),
        .less      (1'b0),
        .A_invert  (ctrl_q[3]),
        .B_invert  (ctrl_q[2]),
        .cin       (carry_q),
        .operation (ctrl_q[1:0]),
        .result    (sl_res),
        .cout      (sl_cout),
        .set       (sl_set)
    );

    // Decode of the latched control word and MSB bookkeeping
    always_comb begin
        last      = (idx_q == IW'(WIDTH - 1));
        slt_set   = sum_msb_q ^ (cin_msb_q ^ cout_msb_q);
        is_arith  = (ctrl_q == 4'b0010) || (ctrl_q == 4'b0110);
        is_slt    = (ctrl_q == 4'b0111);
        supported = is_arith || is_slt ||
                    (ctrl_q == 4'b0000) ||
                    (ctrl_q == 4'b0001) ||
                    (ctrl_q == 4'b1100);
        // On the last RUN cycle the MSB carries are still live on the slice
        cin_m     = (state == RUN) ? carry_q : cin_msb_q;
        cout_m    = (state == RUN) ? sl_cout : cout_msb_q;
        shreg_d   = shreg_q;
        if (state == RUN) begin
            shreg_d = {sl_res, shreg_q[WIDTH-1:1]};
        end else if (state == SLT_FIX) begin
            shreg_d = {shreg_q[WIDTH-1:1], slt_set};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state and status outputs
    always_comb begin
        state_d = state;
        busy    = (state != IDLE);
        done    = (state == FIN);
        unique case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)
                         state_d = (ctrl_q[1:0] == 2'b11) ? SLT_FIX : FIN;
            SLT_FIX: state_d = FIN;
            FIN:     state_d = IDLE;
        endcase
        to_fin = (state_d == FIN) && (state != FIN);
    end

    // Operand latch, bit index, carry chain and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            shreg_q    <= '0;
            cin_msb_q  <= 1'b0;
            cout_msb_q <= 1'b0;
            sum_msb_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= src1;
                        b_q     <= src2;
                        ctrl_q  <= ALU_control;
                        idx_q   <= '0;
                        carry_q <= ALU_control[2];
                        shreg_q <= '0;
                    end
                end
                RUN: begin
                    shreg_q <= shreg_d;
                    carry_q <= sl_cout;
                    if (last) begin
                        cin_msb_q  <= carry_q;
                        cout_msb_q <= sl_cout;
                        sum_msb_q  <= sl_set;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                SLT_FIX: shreg_q <= shreg_d;
                FIN: ;
            endcase
        end
    end

    // Result and flags load on entry to FIN so they are valid with done
    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (to_fin) begin
            result   <= supported ? shreg_d : '0;
            zero     <= supported && (shreg_d == '0);
            cout     <= (is_arith || is_slt) && cout_m;
            overflow <= is_arith && (cin_m ^ cout_m);
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Randomized and directed bench for alu_serial_ctrl.
// Expected values come from a word-level arithmetic model.

module tb_alu_serial_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   ALU_control;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Word-level reference model
    function automatic void model(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic [3:0]   c,
        output logic [W-1:0] r,
        output logic         z,
        output logic         co,
        output logic         ov,
        output int           lat
    );
        logic [W:0] s;
        logic       sup;
        r   = '0;
        co  = 1'b0;
        ov  = 1'b0;
        sup = 1'b1;
        lat = (c[1:0] == 2'b11) ? W + 2 : W + 1;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[W-1:0];
                co = s[W];
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110: begin
                s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r  = s[W-1:0];
                co = s[W];
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0111: begin
                s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                co = s[W];
                r  = ($signed(a) < $signed(b)) ? W'(1) : '0;
            end
            4'b1100: r = ~(a | b);
            default: sup = 1'b0;
        endcase
        z = sup && (r == '0);
    endfunction

    // Drive one operation and collect what the DUT delivers
    task automatic do_op(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic [3:0]   c,
        output int           lat,
        output logic [W-1:0] r,
        output logic         z,
        output logic         co,
        output logic         ov,
        output logic         busy_ok,
        output logic         busy_after
    );
        @(negedge clk);
        src1 = a;
        src2 = b;
        ALU_control = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src1 = $urandom;
        src2 = $urandom;
        lat = -1;
        busy_ok = 1'b1;
        r = 'x; z = 1'bx; co = 1'bx; ov = 1'bx;
        for (int cyc = 1; cyc < W + 20; cyc++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = cyc;
                r = result; z = zero; co = cout; ov = overflow;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        src1 = '0;
        src2 = '0;
        ALU_control = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, zero, cout, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b res=%h z=%b c=%b v=%b want all 0",
                     busy, done, result, zero, cout, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[10];
        logic [W-1:0] tb_[10];
        logic [3:0]   tc[10];
        logic [W-1:0] r, er;
        logic         z, co, ov, bok, baf, ez, eco, eov;
        int           lat, elat;
        ta = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0,
               32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678, 32'hFFFFFFFF, 32'd3};
        tb_ = '{32'h00000001, 32'd5, 32'd1, 32'h80000000, 32'd0,
                32'hFF00FF00, 32'hFF00FF00, 32'h9ABCDEF0, 32'd1, 32'd7};
        tc = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1100,
               4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
        for (int k = 0; k < 10; k++) begin
            model(ta[k], tb_[k], tc[k], er, ez, eco, eov, elat);
            do_op(ta[k], tb_[k], tc[k], lat, r, z, co, ov, bok, baf);
            checks++;
            if (lat !== elat) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d want %0d", k, lat, elat);
            end
            checks++;
            if ({r, z, co, ov} !== {er, ez, eco, eov}) begin
                errors++;
                $display("FAIL dir_result[%0d] ctrl=%b: got %h z%b c%b v%b want %h z%b c%b v%b",
                         k, tc[k], r, z, co, ov, er, ez, eco, eov);
            end
            checks++;
            if (bok !== 1'b1 || baf !== 1'b0) begin
                errors++;
                $display("FAIL dir_busy[%0d]: got during=%b after=%b want 1 0", k, bok, baf);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]   codes[8];
        logic [W-1:0] a, b, r, er;
        logic [3:0]   c;
        logic         z, co, ov, bok, baf, ez, eco, eov;
        int           lat, elat;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                  4'b0111, 4'b1100, 4'b0111, 4'b0110};
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = $urandom;
            if (k % 7 == 3) b = a;
            if (k % 11 == 5) a = {1'b1, {(W-1){1'b0}}};
            c = (k % 9 == 8) ? 4'($urandom) : codes[$urandom_range(0, 7)];
            model(a, b, c, er, ez, eco, eov, elat);
            do_op(a, b, c, lat, r, z, co, ov, bok, baf);
            checks++;
            if (lat !== elat || {r, z, co, ov} !== {er, ez, eco, eov} || bok !== 1'b1) begin
                errors++;
                $display("FAIL rand[%0d] %h %h %b: got lat%0d %h z%b c%b v%b want lat%0d %h z%b c%b v%b",
                         k, a, b, c, lat, r, z, co, ov, elat, er, ez, eco, eov);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] er;
        logic         ez, eco, eov, bok;
        int           lat, elat;
        model(32'h00001111, 32'h00002222, 4'b0010, er, ez, eco, eov, elat);
        @(negedge clk);
        src1 = 32'h00001111;
        src2 = 32'h00002222;
        ALU_control = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        bok = 1'b1;
        for (int cyc = 1; cyc < W + 20; cyc++) begin
            if (done) begin
                lat = cyc;
                break;
            end
            if (!busy) bok = 1'b0;
            if (cyc == 9) begin
                src1 = 32'hDEADBEEF;
                src2 = 32'h0BADF00D;
                ALU_control = 4'b0110;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (lat !== elat || result !== er || overflow !== eov || cout !== eco) begin
            errors++;
            $display("FAIL busy_ignore: got lat%0d %h c%b v%b want lat%0d %h c%b v%b",
                     lat, result, cout, overflow, elat, er, eco, eov);
        end
        checks++;
        if (bok !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore_busy: got %b want 1", bok);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_requeue: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] r, er;
        logic         z, co, ov, bok, baf, ez, eco, eov, saw_done;
        int           lat, elat;
        saw_done = 1'b0;
        @(negedge clk);
        src1 = 32'h0000ABCD;
        src2 = 32'h00001234;
        ALU_control = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 15; cyc++) begin
            if (done) saw_done = 1'b1;
            if (cyc == 14) rst = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (saw_done !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done seen=%b now=%b want 0 0", saw_done, done);
        end
        checks++;
        if (busy !== 1'b0 || result !== '0 || {zero, cout, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL abort_clear: got busy=%b res=%h flags=%b%b%b want 0 0 000",
                     busy, result, zero, cout, overflow);
        end
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_late_done: got done=1 want 0");
        end
        model(32'h0000ABCD, 32'h00001234, 4'b0010, er, ez, eco, eov, elat);
        do_op(32'h0000ABCD, 32'h00001234, 4'b0010, lat, r, z, co, ov, bok, baf);
        checks++;
        if (lat !== elat || r !== er || {z, co, ov} !== {ez, eco, eov}) begin
            errors++;
            $display("FAIL abort_recover: got lat%0d %h want lat%0d %h", lat, r, elat, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r1, r2;
        logic         z1, c1, v1, z2, c2, v2, bok, baf;
        int           lat, l1, l2;
        logic [W-1:0] prev;
        model(32'h00000100, 32'h00000011, 4'b0110, r1, z1, c1, v1, l1);
        model(32'hFFFF0000, 32'h0000FFFF, 4'b0001, r2, z2, c2, v2, l2);
        @(negedge clk);
        src1 = 32'h00000100;
        src2 = 32'h00000011;
        ALU_control = 4'b0110;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int cyc = 1; cyc < W + 20; cyc++) begin
            if (done) begin
                lat = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        prev = result;
        checks++;
        if (lat !== l1 || prev !== r1) begin
            errors++;
            $display("FAIL b2b_first: got lat%0d %h want lat%0d %h", lat, prev, l1, r1);
        end
        src1 = 32'hFFFF0000;
        src2 = 32'h0000FFFF;
        ALU_control = 4'b0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fin_ignore: got busy=%b done=%b want 0 0", busy, done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || result !== r1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b res=%h want 1 %h", busy, result, r1);
        end
        lat = -1;
        for (int cyc = 1; cyc < W + 20; cyc++) begin
            if (done) begin
                lat = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (lat !== l2 || result !== r2 || {zero, cout, overflow} !== {z2, c2, v2}) begin
            errors++;
            $display("FAIL b2b_second: got lat%0d %h want lat%0d %h", lat, result, l2, r2);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
